// File: rtl/vga_pkg.sv
// Shared raster timing constants and types for the VGA output path
// (timing generator, sprite ROM and colour mixer).
package vga_pkg;

    localparam int COORD_W = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    function automatic int span_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOTAL = span_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = span_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    // Bundle of the signals that travel through the alignment delay line.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
    } raster_sig_t;

endpackage

// File: rtl/vga_timing_sig_delay.sv
// Parameterised clock-rate shift register with an asynchronous reset value.
// DEPTH = 0 degenerates to a straight wire.
module sig_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_reg [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_reg[i] <= RST_VAL;
                    end
                end else begin
                    stage_reg[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_reg[i] <= stage_reg[i-1];
                    end
                end
            end

            assign dout = stage_reg[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: pixel-tick divider, x/y counters, wrap pulses and
// sync/blank decode delayed to line up with the sprite ROM's registered data.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int CLK_DIV    = 2,
    parameter bit SYNC_POL   = SYNC_ACTIVE_LOW,
    parameter int PIPE_DELAY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [COORD_W-1:0] current_pixel_x,
    output logic [COORD_W-1:0] current_pixel_y,
    output logic               pix_tick,
    output logic               line_start,
    output logic               frame_start,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on
);

    localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CMP_W   = COORD_W + 1;

    generate
        if (H_TOTAL > 2**COORD_W || V_TOTAL > 2**COORD_W) begin : g_bad_total
            $error("vga_timing: H_TOTAL/V_TOTAL do not fit the coordinate width");
        end
        if (CLK_DIV < 1) begin : g_bad_div
            $error("vga_timing: CLK_DIV must be at least 1");
        end
        if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_delay
            $error("vga_timing: PIPE_DELAY must be in 0..7");
        end
    endgenerate

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_TOTAL - 1);
    // Decode bounds are one bit wider so an active span of 2**COORD_W still compares correctly.
    localparam logic [CMP_W-1:0] X_ACT_END = CMP_W'(H_ACTIVE);
    localparam logic [CMP_W-1:0] Y_ACT_END = CMP_W'(V_ACTIVE);
    localparam logic [CMP_W-1:0] HS_START  = CMP_W'(H_ACTIVE + H_FP);
    localparam logic [CMP_W-1:0] HS_END    = CMP_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CMP_W-1:0] VS_START  = CMP_W'(V_ACTIVE + V_FP);
    localparam logic [CMP_W-1:0] VS_END    = CMP_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam raster_sig_t      SIG_IDLE  = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, video_on: 1'b0};

    logic [DIV_W-1:0]   div_cnt_reg;
    logic [COORD_W-1:0] x_reg;
    logic [COORD_W-1:0] y_reg;
    logic               x_wrap;
    logic [CMP_W-1:0]   x_ext;
    logic [CMP_W-1:0]   y_ext;
    raster_sig_t        raw_sig;
    raster_sig_t        dly_sig;

    assign pix_tick = en && (div_cnt_reg == DIV_LAST);
    assign x_wrap   = pix_tick && (x_reg == X_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_reg <= '0;
            x_reg       <= '0;
            y_reg       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= x_wrap;
            frame_start <= x_wrap && (y_reg == Y_LAST);
            if (en) begin
                div_cnt_reg <= (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + DIV_W'(1);
            end
            if (pix_tick) begin
                if (x_reg == X_LAST) begin
                    x_reg <= '0;
                    y_reg <= (y_reg == Y_LAST) ? '0 : y_reg + COORD_W'(1);
                end else begin
                    x_reg <= x_reg + COORD_W'(1);
                end
            end
        end
    end

    assign x_ext = {1'b0, x_reg};
    assign y_ext = {1'b0, y_reg};

    always_comb begin
        raw_sig          = SIG_IDLE;
        raw_sig.video_on = (x_ext < X_ACT_END) && (y_ext < Y_ACT_END);
        if (x_ext >= HS_START && x_ext < HS_END) begin
            raw_sig.hsync = SYNC_POL;
        end
        if (y_ext >= VS_START && y_ext < VS_END) begin
            raw_sig.vsync = SYNC_POL;
        end
    end

    sig_delay #(
        .WIDTH   (3),
        .DEPTH   (PIPE_DELAY),
        .RST_VAL (SIG_IDLE)
    ) u_sig_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (raw_sig),
        .dout (dly_sig)
    );

    assign current_pixel_x = x_reg;
    assign current_pixel_y = y_reg;
    assign hsync           = dly_sig.hsync;
    assign vsync           = dly_sig.vsync;
    assign video_on        = dly_sig.video_on;

endmodule
